// File: rtl/monitor_dmem_ctrl.sv
// monitor_dmem_ctrl
//
// Lets a debug monitor on an Avalon-MM slave read or write single words of the
// CPU data memory. The memory has one port, and the CPU owns it by default.
// A monitor request waits while the CPU is using the port. If the CPU keeps
// the port for MAX_WAIT cycles, the controller stalls the CPU and takes the
// port for one access cycle.
//
// Ports
//   clk, reset         single clock, asynchronous active-high reset
//   avs_*              Avalon-MM slave with zero wait states and registered
//                      read data
//                        0 ADDR   (rw)
//                        1 WDATA  (rw)
//                        2 CTRL (write) / STATUS (read)
//                        3 RDATA  (ro)
//   cpu_*              CPU data-memory request side; cpu_stall holds the CPU
//   mem_*              shared synchronous data-memory port; read data is valid
//                      one cycle after the address

module monitor_dmem_ctrl #(
    parameter int AW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    output logic [31:0]   avs_readdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int              WCW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MAX_WAIT - 1);
    localparam logic [WCW-1:0]  WAIT_MAX  = WCW'(MAX_WAIT);

    localparam logic [1:0] REG_ADDR  = 2'd0;
    localparam logic [1:0] REG_WDATA = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_RDATA = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FORCE,
        ACCESS,
        CAPTURE
    } stateT;

    stateT           state_q, state_d;
    logic [WCW-1:0]  waitCnt_q, waitCnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            opWrite_q, opWrite_d;
    logic [31:0]     readData_q, readData_d;

    logic            busy;
    logic            stallInt;
    logic            startCmd;

    assign busy     = (state_q != IDLE);
    assign stallInt = (state_q == FORCE) || (state_q == ACCESS);

    // Next-state logic for the register file and the arbitration FSM.
    // Register writes are decoded first, so an FSM event in the same cycle
    // (setting DONE) takes priority over a DONE clear. Read data is taken
    // from the next-state values so that a read returns what the registers
    // hold after this edge. This includes a STATUS change on the same edge.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = done_q;
        err_d      = err_q;
        opWrite_d  = opWrite_q;
        readData_d = readData_q;
        startCmd   = 1'b0;

        if (avs_write) begin
            case (avs_address)
                REG_ADDR: begin
                    if (busy) err_d = 1'b1;
                    else      addr_d = avs_writedata[AW-1:0];
                end
                REG_WDATA: begin
                    if (busy) err_d = 1'b1;
                    else      wdata_d = avs_writedata;
                end
                REG_CTRL: begin
                    if (avs_writedata[2]) begin
                        err_d  = 1'b0;
                        done_d = 1'b0;
                    end
                    // Asking for read and write at once is a command error.
                    if (avs_writedata[0] && avs_writedata[1]) begin
                        err_d = 1'b1;
                    end else if (avs_writedata[0] || avs_writedata[1]) begin
                        if (busy) begin
                            err_d = 1'b1;
                        end else begin
                            startCmd  = 1'b1;
                            done_d    = 1'b0;
                            opWrite_d = avs_writedata[1];
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (startCmd) begin
                    state_d   = REQ;
                    waitCnt_d = '0;
                end
            end
            REQ: begin
                // The CPU keeps the port while it uses it. The counter stops
                // at MAX_WAIT instead of wrapping.
                if (!cpu_req) begin
                    state_d = ACCESS;
                end else if (waitCnt_q >= WAIT_LAST) begin
                    state_d   = FORCE;
                    waitCnt_d = WAIT_MAX;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            FORCE: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (opWrite_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d = mem_rdata;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (avs_read) begin
            case (avs_address)
                REG_ADDR:  readData_d = 32'(addr_d);
                REG_WDATA: readData_d = wdata_d;
                REG_CTRL:  readData_d = {29'd0, err_d, done_d, (state_d != IDLE)};
                REG_RDATA: readData_d = rdata_d;
                default:   readData_d = 32'd0;
            endcase
        end
    end

    // The monitor drives the memory port only in ACCESS. At all other times
    // the CPU drives it, and a CPU write is gated while the CPU is stalled.
    // Reset forces the state to IDLE, so an access in progress stops at once
    // without a write.
    always_comb begin
        cpu_stall = stallInt;
        cpu_rdata = mem_rdata;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we & ~stallInt;
        if (state_q == ACCESS) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_we    = opWrite_q;
        end
    end

    // State and register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            opWrite_q  <= 1'b0;
            readData_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            opWrite_q  <= opWrite_d;
            readData_q <= readData_d;
        end
    end

    assign avs_readdata = readData_q;

endmodule

// File: doc/monitor_dmem_ctrl.md
MONITOR_DMEM_CTRL -- requirements
Module: monitor_dmem_ctrl

Interface
REQ-001 Parameter AW, default 8: data-memory word-address width.
REQ-002 Parameter MAX_WAIT, default 15: cycles a pending monitor request yields to the CPU before forcing a stall.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 avs_address  in  2  Avalon-MM slave register select.
REQ-006 avs_read / avs_write  in  1 each  Avalon-MM read/write strobes; zero wait states.
REQ-007 avs_writedata  in  32  register write data.
REQ-008 avs_readdata  out  32  registered read data, valid the cycle after avs_read.
REQ-009 cpu_req, cpu_we  in  1 each  CPU data-memory access request and write enable.
REQ-010 cpu_addr  in  AW; cpu_wdata  in  32  CPU word address and write data.
REQ-011 cpu_rdata  out  32  pass-through of mem_rdata.
REQ-012 cpu_stall  out  1  CPU shall hold its access while high.
REQ-013 mem_addr  out  AW; mem_we  out  1; mem_wdata  out  32  shared data-memory port.
REQ-014 mem_rdata  in  32  synchronous memory read data, valid one cycle after mem_addr.

Function
REQ-015 Register map: 0 ADDR (rw, bits AW-1:0); 1 WDATA (rw); 2 CTRL/STATUS; 3 RDATA (ro); unused bits read 0.
REQ-016 CTRL write: bit0=start read, bit1=start write, bit2=1 clears ERR and DONE; bit0 and bit1 both set = no start, ERR set.
REQ-017 STATUS read: bit0 BUSY (state != IDLE), bit1 DONE (sticky), bit2 ERR (sticky).
REQ-018 Any write to ADDR, WDATA or a start command while BUSY shall be ignored and shall set ERR.
REQ-019 A start while IDLE shall clear DONE, latch the operation and enter REQ on the next edge.
REQ-020 FSM states: IDLE, REQ, FORCE, ACCESS, CAPTURE.
REQ-021 REQ: if cpu_req=0 go ACCESS; else increment wait_cnt; when wait_cnt reaches MAX_WAIT go FORCE.
REQ-022 FORCE: cpu_stall=1, port still driven by CPU with mem_we=0; next state ACCESS unconditionally.
REQ-023 ACCESS: cpu_stall=1, mem_addr=ADDR, mem_wdata=WDATA, mem_we=1 only for write.
REQ-024 ACCESS exit: write goes IDLE with DONE=1; read goes CAPTURE.
REQ-025 CAPTURE: RDATA<=mem_rdata, DONE<=1, cpu_stall=0, port returned to CPU; next state IDLE.
REQ-026 Outside ACCESS: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we&~cpu_stall (combinational).
REQ-027 cpu_stall shall be high only in FORCE and ACCESS.
REQ-028 wait_cnt shall be cleared on entry to REQ; it is 4 bits wide for the default and shall not wrap.
REQ-029 Monitor access latency with CPU idle: start edge T -> ACCESS at T+2, write DONE at T+3, read RDATA/DONE at T+4.
REQ-030 avs_readdata shall reflect register contents at the sampling edge, including STATUS updated the same edge.

Reset
REQ-031 Reset shall force IDLE, wait_cnt=0, ADDR=WDATA=RDATA=0, DONE=ERR=0, avs_readdata=0.
REQ-032 During reset cpu_stall=0 and mem_we follows REQ-026; reset mid-access shall abort without memory write.

Verification
REQ-033 Reset: assert reset with cpu_req=0 -> all STATUS bits 0, avs_readdata=0, cpu_stall=0, mem_we=0.
REQ-034 Read, CPU idle: mem[0x10]=0xDEADBEEF, ADDR=0x10, CTRL=1 -> mem_addr=0x10 one cycle, RDATA=0xDEADBEEF, STATUS=0x2 after 4 cycles.
REQ-035 Write with cpu_req held high: ADDR=0x22, WDATA=0x12345678, CTRL=2 -> 15 REQ cycles, FORCE, ACCESS with mem_we=1 and mem_wdata=0x12345678; no CPU write while cpu_stall=1.
REQ-036 Busy violation: CTRL=1 then ADDR=0x05 while BUSY -> ADDR unchanged, ERR=1; CTRL=4 -> STATUS=0x0.
REQ-037 Reset mid-access: assert reset in ACCESS of a write -> mem_we=0 immediately, STATUS=0, memory unchanged.
REQ-038 CPU pass-through: FSM IDLE, cpu_req=1, cpu_we=1, cpu_addr=0x03, cpu_wdata=0xA5 -> mem_we=1, mem_addr=0x03, cpu_stall=0.
